// File: rtl/id_ctrl_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ctrl_stage_pkg
// Description : Shared definitions for the buffered decode stage: control
//               field encodings, the packed control bundle layout, mul/div
//               opcodes and codes, and the issue FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ctrl_stage_pkg;

    // Next-PC selection
    localparam logic [3:0] NPC_PC4  = 4'd0, NPC_B   = 4'd1, NPC_JIRL = 4'd2,
                           NPC_BEQ  = 4'd3, NPC_BNE = 4'd4, NPC_BLT  = 4'd5,
                           NPC_BGE  = 4'd6, NPC_BLTU = 4'd7, NPC_BGEU = 4'd8;
    // Immediate extension
    localparam logic [2:0] EXT_NONE = 3'd0, EXT_5U  = 3'd1, EXT_12S = 3'd2,
                           EXT_12U  = 3'd3, EXT_20  = 3'd4, EXT_16S = 3'd5,
                           EXT_26S  = 3'd6;
    // Load data extension
    localparam logic [2:0] RAM_EXT_W = 3'd0, RAM_EXT_B = 3'd1, RAM_EXT_H = 3'd2,
                           RAM_EXT_BU = 3'd3, RAM_EXT_HU = 3'd4;
    // ALU operation
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd2,
                           ALU_SLTU = 4'd3, ALU_AND = 4'd4, ALU_OR = 4'd5,
                           ALU_NOR = 4'd6, ALU_XOR = 4'd7, ALU_SLL = 4'd8,
                           ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;
    // Store byte enables
    localparam logic [1:0] RAM_WE_N = 2'd0, RAM_WE_B = 2'd1, RAM_WE_H = 2'd2,
                           RAM_WE_W = 2'd3;
    // Operand / writeback selects
    localparam logic       R2_RK = 1'b0, R2_RD = 1'b1;
    localparam logic       WR_RD = 1'b0, WR_R1 = 1'b1;
    localparam logic [1:0] WD_ALU = 2'd0, WD_RAM = 2'd1, WD_PC4 = 2'd2;
    localparam logic       ALUA_R1 = 1'b0, ALUA_PC = 1'b1;
    localparam logic       ALUB_R2 = 1'b0, ALUB_EXT = 1'b1;

    // Mul/div family, inst[31:15]
    localparam logic [16:0] OP_MUL_W  = 17'h00038, OP_MULH_W = 17'h00039,
                            OP_MULH_WU = 17'h0003A, OP_DIV_W = 17'h00040,
                            OP_MOD_W  = 17'h00041, OP_DIV_WU = 17'h00042,
                            OP_MOD_WU = 17'h00043;
    localparam logic [2:0]  MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHU = 3'd2,
                            MD_DIV = 3'd3, MD_MOD = 3'd4, MD_DIVU = 3'd5,
                            MD_MODU = 3'd6;

    // Control bundle; first field is the MSB, illegal is bit 0
    typedef struct packed {
        logic [3:0] npc_op;
        logic [2:0] ext_op;
        logic [2:0] ram_ext_op;
        logic [3:0] alu_op;
        logic       rf_we;
        logic [1:0] ram_we;
        logic       r2_sel;
        logic       wr_sel;
        logic [1:0] wd_sel;
        logic       rR1_re;
        logic       rR2_re;
        logic       alua_sel;
        logic       alub_sel;
        logic       is_br_jump;
        logic [2:0] md_op;
        logic       is_md;
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    // Mul opcodes (bit6=0) map to 0..2, div/mod opcodes (bit6=1) to 3..6
    function automatic logic [2:0] md_op_of(input logic is_div, input logic [1:0] sel);
        return is_div ? ({1'b0, sel} + 3'd3) : {1'b0, sel};
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ctrl_stage_decode.sv
`default_nettype none
// ============================================================================
// Module      : id_decode
// Description : Combinational LA32R decoder, inst[31:15] -> control bundle.
//               Ports: i_op (inst[31:15]), o_ctrl (decoded bundle).
//               Unmatched opcodes produce an illegal, side-effect-free bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module id_decode
    import id_ctrl_stage_pkg::*;
#(
    parameter bit EN_MULDIV = 1'b1
) (
    input  logic [16:0] i_op,
    output ctrl_t       o_ctrl
);

    ctrl_t w_c;
    logic  w_is_3r, w_is_imm, w_is_st, w_is_cbr;

    always_comb begin
        w_c        = '0;
        w_c.npc_op = NPC_PC4;
        w_c.ram_we = RAM_WE_N;
        w_c.wd_sel = WD_ALU;
        w_c.illegal = 1'b1;
        w_is_3r  = 1'b0;
        w_is_imm = 1'b0;
        w_is_st  = 1'b0;
        w_is_cbr = 1'b0;
        casez (i_op)
            17'h00020: begin w_is_3r = 1'b1; w_c.alu_op = ALU_ADD;  end
            17'h00022: begin w_is_3r = 1'b1; w_c.alu_op = ALU_SUB;  end
            17'h00024: begin w_is_3r = 1'b1; w_c.alu_op = ALU_SLT;  end
            17'h00025: begin w_is_3r = 1'b1; w_c.alu_op = ALU_SLTU; end
            17'h00028: begin w_is_3r = 1'b1; w_c.alu_op = ALU_NOR;  end
            17'h00029: begin w_is_3r = 1'b1; w_c.alu_op = ALU_AND;  end
            17'h0002A: begin w_is_3r = 1'b1; w_c.alu_op = ALU_OR;   end
            17'h0002B: begin w_is_3r = 1'b1; w_c.alu_op = ALU_XOR;  end
            17'h0002E: begin w_is_3r = 1'b1; w_c.alu_op = ALU_SLL;  end
            17'h0002F: begin w_is_3r = 1'b1; w_c.alu_op = ALU_SRL;  end
            17'h00030: begin w_is_3r = 1'b1; w_c.alu_op = ALU_SRA;  end
            OP_MUL_W, OP_MULH_W, OP_MULH_WU,
            OP_DIV_W, OP_MOD_W, OP_DIV_WU, OP_MOD_WU: begin
                // With the unit absent these stay on the illegal default
                if (EN_MULDIV) begin
                    w_is_3r   = 1'b1;
                    w_c.is_md = 1'b1;
                    w_c.md_op = md_op_of(i_op[6], i_op[1:0]);
                end
            end
            17'h00081: begin w_is_imm = 1'b1; w_c.ext_op = EXT_5U; w_c.alu_op = ALU_SLL; end
            17'h00089: begin w_is_imm = 1'b1; w_c.ext_op = EXT_5U; w_c.alu_op = ALU_SRL; end
            17'h00091: begin w_is_imm = 1'b1; w_c.ext_op = EXT_5U; w_c.alu_op = ALU_SRA; end
            17'b0000001000_???????: begin w_is_imm = 1'b1; w_c.ext_op = EXT_12S; w_c.alu_op = ALU_SLT;  end
            17'b0000001001_???????: begin w_is_imm = 1'b1; w_c.ext_op = EXT_12S; w_c.alu_op = ALU_SLTU; end
            17'b0000001010_???????: begin w_is_imm = 1'b1; w_c.ext_op = EXT_12S; w_c.alu_op = ALU_ADD;  end
            17'b0000001101_???????: begin w_is_imm = 1'b1; w_c.ext_op = EXT_12U; w_c.alu_op = ALU_AND;  end
            17'b0000001110_???????: begin w_is_imm = 1'b1; w_c.ext_op = EXT_12U; w_c.alu_op = ALU_OR;   end
            17'b0000001111_???????: begin w_is_imm = 1'b1; w_c.ext_op = EXT_12U; w_c.alu_op = ALU_XOR;  end
            17'b0010100000_???????: begin w_is_imm = 1'b1; w_c.ext_op = EXT_12S; w_c.wd_sel = WD_RAM; w_c.ram_ext_op = RAM_EXT_B;  end
            17'b0010100001_???????: begin w_is_imm = 1'b1; w_c.ext_op = EXT_12S; w_c.wd_sel = WD_RAM; w_c.ram_ext_op = RAM_EXT_H;  end
            17'b0010100010_???????: begin w_is_imm = 1'b1; w_c.ext_op = EXT_12S; w_c.wd_sel = WD_RAM; w_c.ram_ext_op = RAM_EXT_W;  end
            17'b0010101000_???????: begin w_is_imm = 1'b1; w_c.ext_op = EXT_12S; w_c.wd_sel = WD_RAM; w_c.ram_ext_op = RAM_EXT_BU; end
            17'b0010101001_???????: begin w_is_imm = 1'b1; w_c.ext_op = EXT_12S; w_c.wd_sel = WD_RAM; w_c.ram_ext_op = RAM_EXT_HU; end
            17'b0010100100_???????: begin w_is_st = 1'b1; w_c.ram_we = RAM_WE_B; end
            17'b0010100101_???????: begin w_is_st = 1'b1; w_c.ram_we = RAM_WE_H; end
            17'b0010100110_???????: begin w_is_st = 1'b1; w_c.ram_we = RAM_WE_W; end
            17'b0001010_??????????: begin  // lu12i.w
                w_c.illegal = 1'b0; w_c.rf_we = 1'b1; w_c.ext_op = EXT_20;
                w_c.alu_op = ALU_LUI; w_c.alub_sel = ALUB_EXT;
            end
            17'b0001110_??????????: begin  // pcaddu12i
                w_c.illegal = 1'b0; w_c.rf_we = 1'b1; w_c.ext_op = EXT_20;
                w_c.alua_sel = ALUA_PC; w_c.alub_sel = ALUB_EXT;
            end
            17'b010011_???????????: begin  // jirl
                w_c.illegal = 1'b0; w_c.npc_op = NPC_JIRL; w_c.ext_op = EXT_16S;
                w_c.rf_we = 1'b1; w_c.rR1_re = 1'b1; w_c.wd_sel = WD_PC4; w_c.is_br_jump = 1'b1;
            end
            17'b010100_???????????: begin  // b
                w_c.illegal = 1'b0; w_c.npc_op = NPC_B; w_c.ext_op = EXT_26S; w_c.is_br_jump = 1'b1;
            end
            17'b010101_???????????: begin  // bl writes the link into r1
                w_c.illegal = 1'b0; w_c.npc_op = NPC_B; w_c.ext_op = EXT_26S; w_c.is_br_jump = 1'b1;
                w_c.rf_we = 1'b1; w_c.wr_sel = WR_R1; w_c.wd_sel = WD_PC4;
            end
            17'b010110_???????????: begin w_is_cbr = 1'b1; w_c.npc_op = NPC_BEQ;  end
            17'b010111_???????????: begin w_is_cbr = 1'b1; w_c.npc_op = NPC_BNE;  end
            17'b011000_???????????: begin w_is_cbr = 1'b1; w_c.npc_op = NPC_BLT;  end
            17'b011001_???????????: begin w_is_cbr = 1'b1; w_c.npc_op = NPC_BGE;  end
            17'b011010_???????????: begin w_is_cbr = 1'b1; w_c.npc_op = NPC_BLTU; end
            17'b011011_???????????: begin w_is_cbr = 1'b1; w_c.npc_op = NPC_BGEU; end
            default: ;
        endcase
        if (w_is_3r) begin
            w_c.illegal = 1'b0; w_c.rf_we = 1'b1; w_c.rR1_re = 1'b1;
            w_c.rR2_re = 1'b1; w_c.alub_sel = ALUB_R2;
        end
        if (w_is_imm) begin
            w_c.illegal = 1'b0; w_c.rf_we = 1'b1; w_c.rR1_re = 1'b1; w_c.alub_sel = ALUB_EXT;
        end
        // Stores and conditional branches read rd as the second source
        if (w_is_st) begin
            w_c.illegal = 1'b0; w_c.rR1_re = 1'b1; w_c.rR2_re = 1'b1; w_c.r2_sel = R2_RD;
            w_c.ext_op = EXT_12S; w_c.alub_sel = ALUB_EXT;
        end
        if (w_is_cbr) begin
            w_c.illegal = 1'b0; w_c.rR1_re = 1'b1; w_c.rR2_re = 1'b1; w_c.r2_sel = R2_RD;
            w_c.ext_op = EXT_16S; w_c.is_br_jump = 1'b1;
        end
    end

    assign o_ctrl = w_c;

endmodule
`default_nettype wire

// File: rtl/id_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ctrl_stage
// Description : Buffered decode stage. Decodes on enqueue, queues up to
//               QDEPTH decoded entries, issues to EX over valid/ready and
//               stalls issue after a mul/div until md_done.
//   Ports: cpu_clk/cpu_rstn; if_valid/if_ready/if_inst/if_pc (fetch side);
//          ex_valid/ex_ready/ex_pc/ex_inst/ex_ctrl (EX side);
//          flush; md_done (mul/div completion); md_wait (interlock active).
// Revision    : 1.0 - initial release
// ============================================================================
module id_ctrl_stage
    import id_ctrl_stage_pkg::*;
#(
    parameter int QDEPTH    = 2,
    parameter int PC_W      = 32,
    parameter bit EN_MULDIV = 1'b1
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_inst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [PC_W-1:0]   ex_pc,
    output logic [31:0]       ex_inst,
    output logic [CTRL_W-1:0] ex_ctrl,
    input  logic              flush,
    input  logic              md_done,
    output logic              md_wait
);

    localparam int           c_aw    = $clog2(QDEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(QDEPTH);

    ctrl_t           w_dec_ctrl;
    ctrl_t           w_head_ctrl;
    ctrl_t           r_ctrl_q [QDEPTH];
    logic [PC_W-1:0] r_pc_q   [QDEPTH];
    logic [31:0]     r_inst_q [QDEPTH];
    logic [c_aw-1:0] r_wptr, r_rptr;
    logic [c_aw:0]   r_count;
    state_t          r_state, w_state_nxt;
    logic            w_enq, w_deq;

    id_decode #(.EN_MULDIV(EN_MULDIV)) u_decode (
        .i_op   (if_inst[31:15]),
        .o_ctrl (w_dec_ctrl)
    );

    // Readiness comes from the registered count only: no ex_ready->if_ready path
    assign if_ready    = (r_count < c_depth);
    assign ex_valid    = (r_state == ST_IDLE) && (r_count != '0);
    assign md_wait     = (r_state == ST_MD_WAIT);
    assign w_enq       = if_valid && if_ready && !flush;
    assign w_deq       = ex_valid && ex_ready && !flush;
    assign w_head_ctrl = r_ctrl_q[r_rptr];

    assign ex_pc   = ex_valid ? r_pc_q[r_rptr]   : '0;
    assign ex_inst = ex_valid ? r_inst_q[r_rptr] : '0;
    assign ex_ctrl = ex_valid ? w_head_ctrl      : '0;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset: it is only visible while ex_valid is high
    always_ff @(posedge cpu_clk) begin
        if (w_enq) begin
            r_ctrl_q[r_wptr] <= w_dec_ctrl;
            r_pc_q[r_wptr]   <= if_pc;
            r_inst_q[r_wptr] <= if_inst;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_deq && w_head_ctrl.is_md) w_state_nxt = ST_MD_WAIT;
            ST_MD_WAIT: if (md_done) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (flush) w_state_nxt = ST_IDLE;
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ctrl_stage
// Description : Directed self-checking bench for id_ctrl_stage. Instance u_a
//               has the mul/div family enabled, u_b has it disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ctrl_stage;
    import id_ctrl_stage_pkg::*;

    localparam logic [31:0] I_ADD  = 32'h0010_0823;  // add.w  r3,r1,r2
    localparam logic [31:0] I_ADDI = 32'h0280_1401;  // addi.w r1,r0,5
    localparam logic [31:0] I_ST   = 32'h2980_2041;  // st.w   r1,r2,8
    localparam logic [31:0] I_MUL  = 32'h001C_0C41;  // mul.w  r1,r2,r3
    localparam logic [31:0] I_DIV  = 32'h0020_0000;  // div.w  r0,r0,r0
    localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

    logic cpu_clk = 1'b0;
    logic cpu_rstn, flush, md_done;
    logic if_valid, if_ready, ex_valid, ex_ready, md_wait;
    logic [31:0] if_inst, if_pc, ex_pc, ex_inst;
    logic [CTRL_W-1:0] ex_ctrl;
    logic b_if_valid, b_if_ready, b_ex_valid, b_ex_ready, b_md_wait;
    logic [31:0] b_if_inst, b_if_pc, b_ex_pc, b_ex_inst;
    logic [CTRL_W-1:0] b_ex_ctrl;

    int n_total = 0, n_pass = 0, n_fail = 0;
    ctrl_t e_add, e_addi, e_st, e_mul, e_div, e_ill;

    always #5 cpu_clk = ~cpu_clk;

    id_ctrl_stage #(.QDEPTH(2), .PC_W(32), .EN_MULDIV(1'b1)) u_a (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .if_valid(if_valid), .if_ready(if_ready),
        .if_inst(if_inst), .if_pc(if_pc), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_ctrl(ex_ctrl), .flush(flush),
        .md_done(md_done), .md_wait(md_wait));

    id_ctrl_stage #(.QDEPTH(2), .PC_W(32), .EN_MULDIV(1'b0)) u_b (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .if_valid(b_if_valid), .if_ready(b_if_ready),
        .if_inst(b_if_inst), .if_pc(b_if_pc), .ex_valid(b_ex_valid), .ex_ready(b_ex_ready),
        .ex_pc(b_ex_pc), .ex_inst(b_ex_inst), .ex_ctrl(b_ex_ctrl), .flush(flush),
        .md_done(md_done), .md_wait(b_md_wait));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1; if_inst = inst; if_pc = pc;
    endtask

    initial begin
        e_add = '0; e_add.alu_op = ALU_ADD; e_add.rf_we = 1'b1; e_add.wd_sel = WD_ALU;
        e_add.rR1_re = 1'b1; e_add.rR2_re = 1'b1; e_add.alub_sel = ALUB_R2;
        e_addi = '0; e_addi.ext_op = EXT_12S; e_addi.alu_op = ALU_ADD; e_addi.rf_we = 1'b1;
        e_addi.rR1_re = 1'b1; e_addi.alub_sel = ALUB_EXT;
        e_st = '0; e_st.ext_op = EXT_12S; e_st.alu_op = ALU_ADD; e_st.ram_we = RAM_WE_W;
        e_st.r2_sel = R2_RD; e_st.rR1_re = 1'b1; e_st.rR2_re = 1'b1; e_st.alub_sel = ALUB_EXT;
        e_mul = e_add; e_mul.is_md = 1'b1; e_mul.md_op = MD_MUL;
        e_div = e_add; e_div.is_md = 1'b1; e_div.md_op = MD_DIV;
        e_ill = '0; e_ill.npc_op = NPC_PC4; e_ill.ram_we = RAM_WE_N; e_ill.illegal = 1'b1;

        cpu_rstn = 1'b0; flush = 1'b0; md_done = 1'b0;
        if_valid = 1'b0; if_inst = '0; if_pc = '0; ex_ready = 1'b0;
        b_if_valid = 1'b0; b_if_inst = '0; b_if_pc = '0; b_ex_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_if_ready", 64'(if_ready), 64'd1);
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_ex_ctrl",  64'(ex_ctrl),  64'd0);
        chk("rst_ex_pc",    64'(ex_pc),    64'd0);
        chk("rst_ex_inst",  64'(ex_inst),  64'd0);
        chk("rst_md_wait",  64'(md_wait),  64'd0);
        chk("rst_b_ready",  64'(b_if_ready), 64'd1);
        cpu_rstn = 1'b1;
        tick();

        // add.w issues the cycle after enqueue
        offer(I_ADD, 32'h1000);
        tick(); if_valid = 1'b0;
        chk("add_valid", 64'(ex_valid), 64'd1);
        chk("add_ctrl",  64'(ex_ctrl),  64'(e_add));
        chk("add_pc",    64'(ex_pc),    64'h1000);
        chk("add_inst",  64'(ex_inst),  64'(I_ADD));
        ex_ready = 1'b1; tick(); ex_ready = 1'b0;
        chk("add_drained", 64'(ex_valid), 64'd0);

        // Fill to QDEPTH, hold a third offer, release one slot
        offer(I_ADDI, 32'h1004); tick();
        chk("fill1_ready", 64'(if_ready), 64'd1);
        offer(I_ST, 32'h1008); tick();
        chk("full_ready", 64'(if_ready), 64'd0);
        offer(I_ADD, 32'h100C); tick();
        chk("held_ready", 64'(if_ready), 64'd0);
        chk("head_addi_ctrl", 64'(ex_ctrl), 64'(e_addi));
        chk("head_addi_pc",   64'(ex_pc),   64'h1004);
        ex_ready = 1'b1; tick(); ex_ready = 1'b0;
        chk("pulse_ready",   64'(if_ready), 64'd1);
        chk("head_st_ctrl",  64'(ex_ctrl),  64'(e_st));
        chk("head_st_pc",    64'(ex_pc),    64'h1008);
        tick(); if_valid = 1'b0;
        chk("refill_ready", 64'(if_ready), 64'd0);
        chk("refill_head",  64'(ex_pc),    64'h1008);
        ex_ready = 1'b1; tick();
        chk("third_pc",   64'(ex_pc),   64'h100C);
        chk("third_inst", 64'(ex_inst), 64'(I_ADD));
        tick(); ex_ready = 1'b0;
        chk("fill_empty", 64'(ex_valid), 64'd0);

        // mul.w interlock
        offer(I_MUL, 32'h2000); tick();
        offer(I_ADD, 32'h2004); tick(); if_valid = 1'b0;
        chk("mul_ctrl", 64'(ex_ctrl), 64'(e_mul));
        ex_ready = 1'b1; tick();
        chk("mul_wait",     64'(md_wait),  64'd1);
        chk("mul_ex_valid", 64'(ex_valid), 64'd0);
        chk("mul_gated",    64'(ex_ctrl),  64'd0);
        tick();
        chk("mul_still",    64'(ex_valid), 64'd0);
        md_done = 1'b1; tick(); md_done = 1'b0;
        chk("md_done_wait", 64'(md_wait),  64'd0);
        chk("md_done_valid", 64'(ex_valid), 64'd1);
        chk("md_done_pc",   64'(ex_pc),    64'h2004);
        tick(); ex_ready = 1'b0;
        chk("mul_empty", 64'(ex_valid), 64'd0);
        md_done = 1'b1; tick(); md_done = 1'b0;
        chk("idle_md_done", 64'(md_wait), 64'd0);

        // Flush while waiting with two entries queued
        offer(I_MUL, 32'h3000); tick();
        ex_ready = 1'b1; offer(I_ADD, 32'h3004); tick();
        ex_ready = 1'b0; offer(I_ADDI, 32'h3008); tick();
        chk("pre_flush_wait",  64'(md_wait),  64'd1);
        chk("pre_flush_ready", 64'(if_ready), 64'd0);
        flush = 1'b1; offer(I_ST, 32'h300C); tick();
        flush = 1'b0; if_valid = 1'b0;
        chk("flush_ready", 64'(if_ready), 64'd1);
        chk("flush_wait",  64'(md_wait),  64'd0);
        chk("flush_valid", 64'(ex_valid), 64'd0);
        tick();
        chk("flush_absent", 64'(ex_valid), 64'd0);
        offer(I_ADD, 32'h4000); tick(); if_valid = 1'b0;
        chk("post_flush_pc", 64'(ex_pc), 64'h4000);
        // Enqueue and dequeue in the flush cycle are both discarded
        flush = 1'b1; ex_ready = 1'b1; offer(I_ADDI, 32'h4004); tick();
        flush = 1'b0; ex_ready = 1'b0; if_valid = 1'b0;
        chk("flush2_valid", 64'(ex_valid), 64'd0);
        chk("flush2_ready", 64'(if_ready), 64'd1);

        // div.w: legal mul/div on u_a, illegal on u_b
        offer(I_DIV, 32'h5000);
        b_if_valid = 1'b1; b_if_inst = I_DIV; b_if_pc = 32'h5000;
        tick(); if_valid = 1'b0; b_if_valid = 1'b0;
        chk("div_ctrl",   64'(ex_ctrl),   64'(e_div));
        chk("b_div_ctrl", 64'(b_ex_ctrl), 64'(e_ill));
        chk("b_div_pc",   64'(b_ex_pc),   64'h5000);
        chk("b_div_inst", 64'(b_ex_inst), 64'(I_DIV));
        ex_ready = 1'b1; b_ex_ready = 1'b1; tick();
        ex_ready = 1'b0; b_ex_ready = 1'b0;
        chk("b_div_no_wait", 64'(b_md_wait),  64'd0);
        chk("b_div_valid",   64'(b_ex_valid), 64'd0);
        chk("a_div_wait",    64'(md_wait),    64'd1);

        // Unknown opcode on u_a, queued during MD_WAIT
        offer(I_BAD, 32'h5004); tick(); if_valid = 1'b0;
        md_done = 1'b1; tick(); md_done = 1'b0;
        chk("bad_ctrl", 64'(ex_ctrl), 64'(e_ill));
        chk("bad_pc",   64'(ex_pc),   64'h5004);

        // Asynchronous reset mid-stream
        offer(I_ADD, 32'h5008); tick(); if_valid = 1'b0;
        chk("pre_rst_full", 64'(if_ready), 64'd0);
        cpu_rstn = 1'b0; #1;
        chk("mid_rst_valid", 64'(ex_valid), 64'd0);
        chk("mid_rst_ready", 64'(if_ready), 64'd1);
        chk("mid_rst_ctrl",  64'(ex_ctrl),  64'd0);
        chk("mid_rst_pc",    64'(ex_pc),    64'd0);
        chk("mid_rst_inst",  64'(ex_inst),  64'd0);
        chk("mid_rst_wait",  64'(md_wait),  64'd0);
        tick();
        cpu_rstn = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
